// File: rtl/minicpu_regfile_alu.sv
// Register file plus ALU for the MiniCPU. It accepts commands over a valid/ready handshake,
// executes single-cycle ALU operations and runs a multi-cycle shift-add multiply.
module minicpu_regfile_alu #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [3:0]                command,
  input  logic [SEL_W-1:0]          dst,
  input  logic [SEL_W-1:0]          src,
  input  logic [WIDTH-1:0]          in,
  output logic [NUM_REGS*WIDTH-1:0] R_out,
  output logic                      carry,
  output logic                      zero,
  output logic                      done,
  output logic                      err,
  output logic                      fsm_state
);

  // Handshake: a command is taken on a rising clock edge when cmd_valid && cmd_ready.
  // cmd_ready depends only on state. Inputs are ignored on any edge where no command is taken.

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam logic [3:0] OP_LOAD = 4'd1;
  localparam logic [3:0] OP_MOV  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;
  localparam logic [3:0] OP_SWAP = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;
  localparam logic [3:0] OP_CLR  = 4'd13;
  localparam logic [3:0] OP_RS14 = 4'd14;
  localparam logic [3:0] OP_RS15 = 4'd15;

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [0:0]         state;
  logic [WIDTH-1:0]   regs [NUM_REGS];

  logic [2*WIDTH-1:0] mul_mcand;
  logic [WIDTH-1:0]   mul_mplier;
  logic [2*WIDTH-1:0] mul_acc;
  logic [2*WIDTH-1:0] mul_acc_next;
  logic [CNT_W-1:0]   mul_cnt;
  logic [SEL_W-1:0]   mul_dst;
  logic [SEL_W-1:0]   mul_src;

  logic               accept;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH:0]     sum;
  logic               wr_dst;
  logic [WIDTH-1:0]   wr_dst_val;
  logic               wr_src;
  logic [WIDTH-1:0]   wr_src_val;
  logic               upd_zero;
  logic               upd_carry;
  logic               new_carry;
  logic               start_mul;
  logic               rsvd;

  assign cmd_ready = (state == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign fsm_state = state;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_rout
    assign R_out[g*WIDTH +: WIDTH] = regs[g];
  end

  always_comb begin
    op_a       = regs[dst];
    op_b       = regs[src];
    sum        = {1'b0, op_a} + {1'b0, op_b};
    wr_dst     = 1'b0;
    wr_dst_val = '0;
    wr_src     = 1'b0;
    wr_src_val = '0;
    upd_zero   = 1'b0;
    upd_carry  = 1'b0;
    new_carry  = 1'b0;
    start_mul  = 1'b0;
    rsvd       = 1'b0;
    case (command)
      OP_LOAD: begin wr_dst = 1'b1; wr_dst_val = in; upd_zero = 1'b1; end
      OP_MOV:  begin wr_dst = 1'b1; wr_dst_val = op_b; upd_zero = 1'b1; end
      OP_ADD: begin
        wr_dst = 1'b1; wr_dst_val = sum[WIDTH-1:0]; upd_zero = 1'b1;
        upd_carry = 1'b1; new_carry = sum[WIDTH];
      end
      OP_SUB: begin
        wr_dst = 1'b1; wr_dst_val = op_a - op_b; upd_zero = 1'b1;
        upd_carry = 1'b1; new_carry = (op_a < op_b);
      end
      OP_AND:  begin wr_dst = 1'b1; wr_dst_val = op_a & op_b; upd_zero = 1'b1; end
      OP_OR:   begin wr_dst = 1'b1; wr_dst_val = op_a | op_b; upd_zero = 1'b1; end
      OP_XOR:  begin wr_dst = 1'b1; wr_dst_val = op_a ^ op_b; upd_zero = 1'b1; end
      OP_NOT:  begin wr_dst = 1'b1; wr_dst_val = ~op_a; upd_zero = 1'b1; end
      OP_SHL: begin
        wr_dst = 1'b1; wr_dst_val = {op_a[WIDTH-2:0], 1'b0}; upd_zero = 1'b1;
        upd_carry = 1'b1; new_carry = op_a[WIDTH-1];
      end
      OP_SHR: begin
        wr_dst = 1'b1; wr_dst_val = {1'b0, op_a[WIDTH-1:1]}; upd_zero = 1'b1;
        upd_carry = 1'b1; new_carry = op_a[0];
      end
      OP_SWAP: begin
        // With dst == src only the dst write happens, which rewrites the same value.
        wr_dst = 1'b1; wr_dst_val = op_b; upd_zero = 1'b1;
        wr_src = (dst != src); wr_src_val = op_a;
      end
      OP_MUL:  start_mul = 1'b1;
      OP_CLR:  begin wr_dst = 1'b1; wr_dst_val = '0; upd_zero = 1'b1; end
      OP_RS14, OP_RS15: rsvd = 1'b1;
      default: ;
    endcase
  end

  assign mul_acc_next = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      carry      <= 1'b0;
      zero       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_acc    <= '0;
      mul_cnt    <= '0;
      mul_dst    <= '0;
      mul_src    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            done <= !start_mul;
            err  <= rsvd;
            if (wr_dst)    regs[dst] <= wr_dst_val;
            if (wr_src)    regs[src] <= wr_src_val;
            if (upd_zero)  zero      <= (wr_dst_val == '0);
            if (upd_carry) carry     <= new_carry;
            if (start_mul) begin
              state      <= S_MUL;
              mul_mcand  <= {{WIDTH{1'b0}}, op_a};
              mul_mplier <= op_b;
              mul_acc    <= '0;
              mul_cnt    <= '0;
              mul_dst    <= dst;
              mul_src    <= src;
            end
          end
        end
        S_MUL: begin
          mul_acc    <= mul_acc_next;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          mul_cnt    <= mul_cnt + CNT_W'(1);
          // The last step commits straight from mul_acc_next, so the multiply occupies exactly WIDTH cycles.
          if (mul_cnt == CNT_LAST) begin
            regs[mul_dst] <= mul_acc_next[WIDTH-1:0];
            if (mul_dst != mul_src) regs[mul_src] <= mul_acc_next[2*WIDTH-1:WIDTH];
            carry <= (mul_acc_next[2*WIDTH-1:WIDTH] != '0);
            zero  <= (mul_acc_next == '0);
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_minicpu_regfile_alu.sv
// Directed self-checking bench for minicpu_regfile_alu (WIDTH=8, NUM_REGS=4).
// The expected values are computed by hand.
module tb_minicpu_regfile_alu;

  logic        clock;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  command;
  logic [1:0]  dst;
  logic [1:0]  src;
  logic [7:0]  in;
  logic [31:0] R_out;
  logic        carry;
  logic        zero;
  logic        done;
  logic        err;
  logic        fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  minicpu_regfile_alu #(.WIDTH(8), .NUM_REGS(4)) dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .command(command), .dst(dst), .src(src), .in(in), .R_out(R_out),
    .carry(carry), .zero(zero), .done(done), .err(err), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] r(input int i);
    return R_out[i*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one command, waits (bounded) for cmd_ready, and returns #1 after the accepting edge.
  task automatic issue(input logic [3:0] c, input logic [1:0] d, input logic [1:0] s,
                       input logic [7:0] v);
    int n;
    cmd_valid = 1'b1; command = c; dst = d; src = s; in = v;
    n = 0;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    if (!cmd_ready) check("issue_ready_timeout", 0, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    check(tag, done, 1'b1);
  endtask

  int busy_cycles;
  int busy_dones;

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; command = '0; dst = '0; src = '0; in = '0;
    tick(); tick();
    check("rst_rout", R_out, 32'h0);
    check("rst_carry", carry, 1'b0);
    check("rst_zero", zero, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    reset_n = 1'b1;
    tick();
    check("rst_ready", cmd_ready, 1'b1);

    // reset asserted in the middle of the run
    issue(4'd1, 2'd3, 2'd0, 8'h55);
    check("pre_rst_r3", r(3), 8'h55);
    reset_n = 1'b0;
    #1;
    check("midrst_rout", R_out, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();

    // LOADs back to back
    issue(4'd1, 2'd0, 2'd0, 8'd255);
    check("load0_done", done, 1'b1);
    check("load0_ready", cmd_ready, 1'b1);
    issue(4'd1, 2'd1, 2'd0, 8'd1);
    check("load1_done", done, 1'b1);
    check("load_r0", r(0), 8'd255);
    check("load_r1", r(1), 8'd1);
    check("load_zero", zero, 1'b0);
    tick();
    check("done_clears", done, 1'b0);

    // ADD / SUB
    issue(4'd3, 2'd0, 2'd1, 8'h00);
    check("add_r0", r(0), 8'd0);
    check("add_carry", carry, 1'b1);
    check("add_zero", zero, 1'b1);
    issue(4'd4, 2'd0, 2'd1, 8'h00);
    check("sub_r0", r(0), 8'd255);
    check("sub_borrow", carry, 1'b1);
    check("sub_zero", zero, 1'b0);

    // shifts and SWAP
    issue(4'd1, 2'd2, 2'd0, 8'h81);
    issue(4'd9, 2'd2, 2'd0, 8'h00);
    check("shl_r2", r(2), 8'h02);
    check("shl_carry", carry, 1'b1);
    issue(4'd10, 2'd2, 2'd0, 8'h00);
    check("shr_r2", r(2), 8'h01);
    check("shr_carry", carry, 1'b0);
    issue(4'd11, 2'd2, 2'd3, 8'h00);
    check("swap_r2", r(2), 8'h00);
    check("swap_r3", r(3), 8'h01);
    check("swap_zero", zero, 1'b1);
    check("swap_carry_hold", carry, 1'b0);

    // MUL 200*3 = 0x258 while a LOAD is held pending
    issue(4'd1, 2'd0, 2'd0, 8'd200);
    issue(4'd1, 2'd1, 2'd0, 8'd3);
    issue(4'd12, 2'd0, 2'd1, 8'h00);
    cmd_valid = 1'b1; command = 4'd1; dst = 2'd3; src = 2'd0; in = 8'h77;
    busy_cycles = 0;
    busy_dones  = 0;
    while (!cmd_ready && busy_cycles < 50) begin
      busy_cycles++;
      if (done) busy_dones++;
      check("mul_busy_r3", r(3), 8'h01);
      tick();
    end
    check("mul_busy_cycles", busy_cycles, 8);
    check("mul_busy_no_done", busy_dones, 0);
    check("mul_done", done, 1'b1);
    check("mul_r0", r(0), 8'h58);
    check("mul_r1", r(1), 8'h02);
    check("mul_carry", carry, 1'b1);
    check("mul_zero", zero, 1'b0);
    tick();
    cmd_valid = 1'b0;
    check("held_load_r3", r(3), 8'h77);
    check("held_load_done", done, 1'b1);

    // MUL with dst == src: 16*16 = 0x100
    issue(4'd1, 2'd2, 2'd0, 8'd16);
    issue(4'd12, 2'd2, 2'd2, 8'h00);
    check("mul_same_no_done_yet", done, 1'b0);
    wait_done("mulsame_done");
    check("mulsame_r2", r(2), 8'h00);
    check("mulsame_r1", r(1), 8'h02);
    check("mulsame_carry", carry, 1'b1);
    check("mulsame_zero", zero, 1'b0);

    // reserved opcodes leave registers and flags alone
    issue(4'd14, 2'd0, 2'd1, 8'hAA);
    check("rsv14_err", err, 1'b1);
    check("rsv14_done", done, 1'b1);
    check("rsv14_regs", R_out, 32'h77_00_02_58);
    check("rsv14_carry", carry, 1'b1);
    check("rsv14_zero", zero, 1'b0);
    tick();
    check("rsv14_err_clear", err, 1'b0);
    issue(4'd15, 2'd3, 2'd3, 8'h00);
    check("rsv15_err", err, 1'b1);
    check("rsv15_regs", R_out, 32'h77_00_02_58);

    // logic ops, MOV, CLR, NOP
    issue(4'd1, 2'd3, 2'd0, 8'h3C);
    issue(4'd5, 2'd3, 2'd1, 8'h00);
    check("and_r3", r(3), 8'h00);
    check("and_zero", zero, 1'b1);
    issue(4'd6, 2'd3, 2'd0, 8'h00);
    check("or_r3", r(3), 8'h58);
    issue(4'd7, 2'd3, 2'd0, 8'h00);
    check("xor_r3", r(3), 8'h00);
    issue(4'd8, 2'd3, 2'd0, 8'h00);
    check("not_r3", r(3), 8'hFF);
    check("not_zero", zero, 1'b0);
    issue(4'd2, 2'd2, 2'd3, 8'h00);
    check("mov_r2", r(2), 8'hFF);
    issue(4'd13, 2'd3, 2'd0, 8'h00);
    check("clr_r3", r(3), 8'h00);
    check("clr_zero", zero, 1'b1);
    issue(4'd0, 2'd0, 2'd0, 8'h00);
    check("nop_done", done, 1'b1);
    check("nop_err", err, 1'b0);
    check("nop_regs", R_out, 32'h00_FF_02_58);
    check("nop_zero_hold", zero, 1'b1);

    // reset 3 cycles into a MUL
    issue(4'd12, 2'd0, 2'd1, 8'h00);
    tick(); tick();
    check("mulrst_busy", cmd_ready, 1'b0);
    reset_n = 1'b0;
    #1;
    check("mulrst_rout", R_out, 32'h0);
    check("mulrst_carry", carry, 1'b0);
    check("mulrst_zero", zero, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    check("mulrst_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    check("mulrst_no_write", R_out, 32'h0);
    check("mulrst_no_done", done, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
